// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake bundle: assembled instruction word, its PC,
// and the valid/ready pair.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [31:0]           insn;
    logic [ADDR_WIDTH-1:0] insn_pc;
    logic                  insn_valid;
    logic                  insn_ready;

    modport master (
        output insn,
        output insn_pc,
        output insn_valid,
        input  insn_ready
    );

    modport slave (
        input  insn,
        input  insn_pc,
        input  insn_valid,
        output insn_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential fetch stage: reads the byte-wide ROM one byte per clock, builds
// little-endian 32-bit words and offers them to the decoder with their PC.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [7:0]            rom_data,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    instruction_fetch_if.master   dec
);

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        VALID  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(3);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           insn_q;
    logic [ADDR_WIDTH-1:0] insn_pc_q;
    logic                  insn_valid_q;
    logic [1:0]            byte_idx;

    // The byte index is the fetch state itself; VALID parks on byte 3 so the
    // ROM address stays put while the decoder stalls.
    assign byte_idx    = (state == VALID) ? 2'd3 : state[1:0];
    assign rom_address = pc + ADDR_WIDTH'(byte_idx);

    assign dec.insn       = insn_q;
    assign dec.insn_pc    = insn_pc_q;
    assign dec.insn_valid = insn_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= FETCH0;
            pc           <= RESET_ADDR;
            insn_q       <= '0;
            insn_pc_q    <= RESET_ADDR;
            insn_valid_q <= 1'b0;
        end else if (pc_load) begin
            // A redirect wins even over a same-cycle handshake; the word the
            // decoder just took still counts as consumed.
            state        <= FETCH0;
            pc           <= pc_load_value & WORD_MASK;
            insn_valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    insn_q[7:0] <= rom_data;
                    state       <= FETCH1;
                end
                FETCH1: begin
                    insn_q[15:8] <= rom_data;
                    state        <= FETCH2;
                end
                FETCH2: begin
                    insn_q[23:16] <= rom_data;
                    state         <= FETCH3;
                end
                FETCH3: begin
                    insn_q[31:24] <= rom_data;
                    insn_pc_q     <= pc;
                    insn_valid_q  <= 1'b1;
                    state         <= VALID;
                end
                VALID: begin
                    if (dec.insn_ready) begin
                        pc           <= pc + ADDR_WIDTH'(4);
                        insn_valid_q <= 1'b0;
                        state        <= FETCH0;
                    end
                end
                default: begin
                    state        <= FETCH0;
                    insn_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push the words the
// decoder should receive; a negedge monitor pops and compares on each handshake.
module tb_instruction_fetch;

    localparam int AW = 10;

    typedef struct {
        logic [31:0]   insn;
        logic [AW-1:0] pc;
    } word_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rom_address;
    logic [7:0]    rom_data;
    logic          pc_load;
    logic [AW-1:0] pc_load_value;
    logic [7:0]    rom [0:(1<<AW)-1];

    word_t expected_q[$];
    int    vectors;
    int    miscompares;

    instruction_fetch_if #(.ADDR_WIDTH(AW)) dec_if ();

    instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .dec           (dec_if.master)
    );

    assign rom_data = rom[rom_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic [AW-1:0] value,
                                 input logic rdy);
        pc_load           = load;
        pc_load_value     = value;
        dec_if.insn_ready = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] insn, input logic [AW-1:0] pc);
        word_t w;
        w.insn = insn;
        w.pc   = pc;
        expected_q.push_back(w);
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_valid"}, 32'(dec_if.insn_valid), 32'd0);
        checkOutput({tag, "_rom_address"}, 32'(rom_address), 32'h000);
        checkOutput({tag, "_insn"}, dec_if.insn, 32'h0);
        checkOutput({tag, "_insn_pc"}, 32'(dec_if.insn_pc), 32'h000);
    endtask

    // Each handshake seen on the falling edge is the word taken at the next rising edge.
    always @(negedge clk) begin
        if (reset && dec_if.insn_valid && dec_if.insn_ready) begin
            if (expected_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got insn %h pc %h, expected none",
                         dec_if.insn, dec_if.insn_pc);
            end else begin
                word_t w;
                w = expected_q.pop_front();
                checkOutput("word_insn", dec_if.insn, w.insn);
                checkOutput("word_pc", 32'(dec_if.insn_pc), 32'(w.pc));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'((i * 7 + 3) & 8'hff);
        {rom[3], rom[2], rom[1], rom[0]}                 = 32'h000002b7;
        {rom[7], rom[6], rom[5], rom[4]}                 = 32'h00100513;
        {rom[19], rom[18], rom[17], rom[16]}             = 32'h00500093;
        {rom[35], rom[34], rom[33], rom[32]}             = 32'h00b52023;
        {rom[1023], rom[1022], rom[1021], rom[1020]}     = 32'h0000006f;

        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        tick(2);
        check_reset_state("reset");

        // First word with the decoder stalled, then released.
        push_word(32'h000002b7, 10'h000);
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            checkOutput("fetch_addr", 32'(rom_address), 32'(k));
            checkOutput("fetch_not_valid", 32'(dec_if.insn_valid), 32'd0);
        end
        tick(1);
        checkOutput("first_valid", 32'(dec_if.insn_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checkOutput("stall_valid", 32'(dec_if.insn_valid), 32'd1);
            checkOutput("stall_insn", dec_if.insn, 32'h000002b7);
            checkOutput("stall_pc", 32'(dec_if.insn_pc), 32'h000);
            checkOutput("stall_addr", 32'(rom_address), 32'h003);
        end
        applyStimulus(1'b0, '0, 1'b1);
        push_word(32'h00100513, 10'h004);
        tick(1);
        checkOutput("next_pc_addr", 32'(rom_address), 32'h004);
        tick(4);
        checkOutput("word4_valid", 32'(dec_if.insn_valid), 32'd1);
        tick(1);

        // Redirect during FETCH2 of the word at 8.
        tick(2);
        checkOutput("fetch2_addr", 32'(rom_address), 32'h00a);
        applyStimulus(1'b1, 10'h013, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("redirect_addr", 32'(rom_address), 32'h010);
        checkOutput("redirect_not_valid", 32'(dec_if.insn_valid), 32'd0);
        push_word(32'h00500093, 10'h010);
        tick(3);
        checkOutput("redirect_still_fetching", 32'(dec_if.insn_valid), 32'd0);
        tick(1);
        checkOutput("redirect_word_valid", 32'(dec_if.insn_valid), 32'd1);
        tick(1);

        // Wrap-around at the top of the address space; low target bits ignored.
        applyStimulus(1'b1, 10'h3fe, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, 1'b1);
        push_word(32'h0000006f, 10'h3fc);
        for (int k = 0; k < 4; k++) begin
            checkOutput("wrap_addr", 32'(rom_address), 32'(10'h3fc + 10'(k)));
            tick(1);
        end
        checkOutput("wrap_valid", 32'(dec_if.insn_valid), 32'd1);
        checkOutput("wrap_insn_pc", 32'(dec_if.insn_pc), 32'h3fc);
        tick(1);
        checkOutput("wrap_next_addr", 32'(rom_address), 32'h000);

        // Redirect in the same cycle as a handshake.
        push_word(32'h000002b7, 10'h000);
        tick(4);
        checkOutput("pre_redirect_valid", 32'(dec_if.insn_valid), 32'd1);
        applyStimulus(1'b1, 10'h020, 1'b1);
        tick(1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("hs_redirect_addr", 32'(rom_address), 32'h020);
        checkOutput("hs_redirect_not_valid", 32'(dec_if.insn_valid), 32'd0);
        push_word(32'h00b52023, 10'h020);
        tick(4);
        checkOutput("target_word_valid", 32'(dec_if.insn_valid), 32'd1);
        tick(1);

        // Reset pulse in FETCH1 drops the partial word at 0x24.
        tick(1);
        checkOutput("fetch1_addr", 32'(rom_address), 32'h025);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check_reset_state("midreset");
        push_word(32'h000002b7, 10'h000);
        tick(4);
        checkOutput("post_reset_valid", 32'(dec_if.insn_valid), 32'd1);
        checkOutput("post_reset_insn", dec_if.insn, 32'h000002b7);
        tick(1);
        applyStimulus(1'b0, '0, 1'b0);
        tick(2);
        checkOutput("words_outstanding", 32'(expected_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
